// File: rtl/multiplier_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_arbiter_if
// Description : Bundle of requester A/B, response and multiplier handshake
//               signals around the shared-multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiplier_arbiter_if #(
   parameter int WIDTH = 4
);
   // Requester side
   logic                 req_a;
   logic                 req_b;
   logic [WIDTH-1:0]     q_a;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     q_b;
   logic [WIDTH-1:0]     r_b;
   logic                 gnt_a;
   logic                 gnt_b;
   logic                 rsp_valid_a;
   logic                 rsp_valid_b;
   logic [2*WIDTH-1:0]   rsp_p_a;
   logic [2*WIDTH-1:0]   rsp_p_b;
   logic                 rsp_err_a;
   logic                 rsp_err_b;
   logic                 busy;
   // Multiplier side
   logic                 mul_start;
   logic [WIDTH-1:0]     mul_q;
   logic [WIDTH-1:0]     mul_r;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_p;
   logic                 mul_ack;

   // Arbiter view
   modport slave (
      input  req_a, req_b, q_a, r_a, q_b, r_b, mul_done, mul_p,
      output gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, rsp_p_a, rsp_p_b,
             rsp_err_a, rsp_err_b, busy, mul_start, mul_q, mul_r, mul_ack
   );

   // Environment view: requesters plus the multiplier instance
   modport master (
      output req_a, req_b, q_a, r_a, q_b, r_b, mul_done, mul_p,
      input  gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, rsp_p_a, rsp_p_b,
             rsp_err_a, rsp_err_b, busy, mul_start, mul_q, mul_r, mul_ack
   );
endinterface
`default_nettype wire

// File: rtl/multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_arbiter
// Description : Round-robin arbiter sharing one sequential multiplier between
//               requesters A and B. Latches the winner's operands, runs the
//               Start/Done/Ack handshake and returns product or timeout error.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_arbiter #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   multiplier_arbiter_if.slave  io_arb
);

   localparam int c_TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_ACK   = 3'd3,
      S_RESP  = 3'd4,
      S_DRAIN = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_owner;   // 0 = A, 1 = B
   logic                  r_last;    // last requester served, 0 = A, 1 = B
   logic [WIDTH-1:0]      r_mul_q;
   logic [WIDTH-1:0]      r_mul_r;
   logic [2*WIDTH-1:0]    r_prod;
   logic [c_TIMER_W-1:0]  r_timer;
   logic [2*WIDTH-1:0]    r_rsp_p_a;
   logic [2*WIDTH-1:0]    r_rsp_p_b;
   logic                  r_rsp_err_a;
   logic                  r_rsp_err_b;

   logic                  w_sel_b;
   logic                  w_timeout;
   logic                  w_gnt_a, w_gnt_b;
   logic                  w_rsp_valid_a, w_rsp_valid_b;
   logic                  w_mul_start, w_mul_ack, w_busy;

   // B wins when it is alone, or when both ask and A was served last
   assign w_sel_b   = io_arb.req_b & (~io_arb.req_a | ~r_last);
   assign w_timeout = (r_timer == c_TIMER_MAX);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state and Moore output decode
   always_comb begin
      w_next        = r_state;
      w_gnt_a       = 1'b0;
      w_gnt_b       = 1'b0;
      w_rsp_valid_a = 1'b0;
      w_rsp_valid_b = 1'b0;
      w_mul_start   = 1'b0;
      w_mul_ack     = 1'b0;
      w_busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            // A result still pending from an abandoned operation blocks grants
            if (io_arb.mul_done)                    w_next = S_DRAIN;
            else if (io_arb.req_a || io_arb.req_b)  w_next = S_START;
         end
         S_START: begin
            w_mul_start = 1'b1;
            w_gnt_a     = ~r_owner;
            w_gnt_b     = r_owner;
            w_next      = S_WAIT;
         end
         S_WAIT: begin
            if (io_arb.mul_done) w_next = S_ACK;
            else if (w_timeout)  w_next = S_RESP;
         end
         S_ACK: begin
            w_mul_ack = 1'b1;
            if (!io_arb.mul_done) w_next = S_RESP;
         end
         S_RESP: begin
            w_rsp_valid_a = ~r_owner;
            w_rsp_valid_b = r_owner;
            w_next        = S_IDLE;
         end
         S_DRAIN: begin
            w_mul_ack = 1'b1;
            if (!io_arb.mul_done) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture, timer, product latch and per-requester response registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_mul_q     <= '0;
         r_mul_r     <= '0;
         r_prod      <= '0;
         r_timer     <= '0;
         r_rsp_p_a   <= '0;
         r_rsp_p_b   <= '0;
         r_rsp_err_a <= 1'b0;
         r_rsp_err_b <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!io_arb.mul_done && (io_arb.req_a || io_arb.req_b)) begin
                  r_owner <= w_sel_b;
                  r_mul_q <= w_sel_b ? io_arb.q_b : io_arb.q_a;
                  r_mul_r <= w_sel_b ? io_arb.r_b : io_arb.r_a;
               end
            end
            S_START: r_timer <= '0;
            S_WAIT: begin
               if (io_arb.mul_done) begin
                  r_prod <= io_arb.mul_p;
               end else if (w_timeout) begin
                  // Response registers load on the edge into RESP so they are
                  // already valid while Rsp_Valid is high
                  if (r_owner) begin
                     r_rsp_p_b   <= '0;
                     r_rsp_err_b <= 1'b1;
                  end else begin
                     r_rsp_p_a   <= '0;
                     r_rsp_err_a <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_ACK: begin
               if (!io_arb.mul_done) begin
                  if (r_owner) begin
                     r_rsp_p_b   <= r_prod;
                     r_rsp_err_b <= 1'b0;
                  end else begin
                     r_rsp_p_a   <= r_prod;
                     r_rsp_err_a <= 1'b0;
                  end
               end
            end
            S_RESP:  r_last <= r_owner;
            default: ;
         endcase
      end
   end

   assign io_arb.gnt_a       = w_gnt_a;
   assign io_arb.gnt_b       = w_gnt_b;
   assign io_arb.rsp_valid_a = w_rsp_valid_a;
   assign io_arb.rsp_valid_b = w_rsp_valid_b;
   assign io_arb.rsp_p_a     = r_rsp_p_a;
   assign io_arb.rsp_p_b     = r_rsp_p_b;
   assign io_arb.rsp_err_a   = r_rsp_err_a;
   assign io_arb.rsp_err_b   = r_rsp_err_b;
   assign io_arb.busy        = w_busy;
   assign io_arb.mul_start   = w_mul_start;
   assign io_arb.mul_q       = r_mul_q;
   assign io_arb.mul_r       = r_mul_r;
   assign io_arb.mul_ack     = w_mul_ack;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_arbiter
// Description : Directed self-checking bench for multiplier_arbiter with a
//               behavioural sequential multiplier (Done d=4 cycles after Start).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_arbiter;

   localparam int WIDTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int c_D     = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   multiplier_arbiter_if #(.WIDTH(WIDTH)) bus ();

   multiplier_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_arb  (bus)
   );

   // Multiplier model: Done d cycles after Start, drops Done one cycle after Ack
   logic       model_en = 1'b1;
   logic       m_hang   = 1'b0;
   logic       m_done;
   logic [7:0] m_p;
   int         m_cnt;
   logic       man_done = 1'b0;
   logic [7:0] man_p    = 8'd0;

   assign bus.mul_done = model_en ? m_done : man_done;
   assign bus.mul_p    = model_en ? m_p    : man_p;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_done <= 1'b0;
         m_p    <= 8'd0;
         m_cnt  <= 0;
      end else if (m_done) begin
         if (bus.mul_ack) m_done <= 1'b0;
      end else if (m_cnt > 1) begin
         m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
         m_cnt  <= 0;
         m_done <= 1'b1;
      end else if (bus.mul_start && !m_hang) begin
         m_cnt <= c_D - 1;
         m_p   <= 8'(bus.mul_q) * 8'(bus.mul_r);
      end
   end

   // Pulse counters sampled mid-cycle
   int n_gnt_a = 0;
   int n_rsp_a = 0;
   always @(negedge clk) begin
      if (bus.gnt_a)       n_gnt_a++;
      if (bus.rsp_valid_a) n_rsp_a++;
   end

   wire logic [32:0] outs = {bus.gnt_a, bus.gnt_b, bus.rsp_valid_a, bus.rsp_valid_b,
                             bus.rsp_err_a, bus.rsp_err_b, bus.busy, bus.mul_start,
                             bus.mul_ack, bus.mul_q, bus.mul_r, bus.rsp_p_a, bus.rsp_p_b};

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input bit sel_b, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(sel_b ? bus.rsp_valid_b : bus.rsp_valid_a) && n < budget);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
      $fatal(1);
   end

   initial begin
      int n;
      int g0;
      int r0;
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      bus.q_a = '0; bus.r_a = '0; bus.q_b = '0; bus.r_b = '0;

      // Reset state
      tick(); tick();
      chk("reset_outputs", 64'(outs), 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", bus.busy, 0);

      // Single request A: 3 x 5
      bus.q_a = 4'd3; bus.r_a = 4'd5; bus.req_a = 1'b1;
      tick();
      chk("single_gnt_a", bus.gnt_a, 1);
      chk("single_gnt_b", bus.gnt_b, 0);
      chk("single_start", bus.mul_start, 1);
      chk("single_mul_q", bus.mul_q, 3);
      chk("single_mul_r", bus.mul_r, 5);
      bus.req_a = 1'b0;
      wait_rsp(1'b0, 20, n);
      chk("single_gnt_to_rsp", n, 7);
      chk("single_rsp_p_a", bus.rsp_p_a, 15);
      chk("single_rsp_err_a", bus.rsp_err_a, 0);
      chk("single_rsp_valid_b", bus.rsp_valid_b, 0);
      chk("single_rsp_p_b", bus.rsp_p_b, 0);
      tick();
      chk("single_gnt_pulses", n_gnt_a, 1);
      chk("single_idle_busy", bus.busy, 0);
      chk("single_rsp_pulse", bus.rsp_valid_a, 0);

      // Contention from reset: A 15x15, B 2x7, both held
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.q_a = 4'd15; bus.r_a = 4'd15; bus.q_b = 4'd2; bus.r_b = 4'd7;
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      tick();
      chk("cont1_gnt_a", bus.gnt_a, 1);
      chk("cont1_gnt_b", bus.gnt_b, 0);
      chk("cont1_mul_q", bus.mul_q, 15);
      wait_rsp(1'b0, 20, n);
      chk("cont1_latency", n, 7);
      chk("cont1_rsp_p_a", bus.rsp_p_a, 225);
      tick(); tick();
      chk("cont2_gnt_b", bus.gnt_b, 1);
      chk("cont2_gnt_a", bus.gnt_a, 0);
      chk("cont2_mul_q", bus.mul_q, 2);
      chk("cont2_mul_r", bus.mul_r, 7);
      wait_rsp(1'b1, 20, n);
      chk("cont2_latency", n, 7);
      chk("cont2_rsp_p_b", bus.rsp_p_b, 14);
      chk("cont2_rsp_p_a_held", bus.rsp_p_a, 225);
      tick(); tick();
      chk("cont3_gnt_a", bus.gnt_a, 1);
      chk("cont3_gnt_b", bus.gnt_b, 0);
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      wait_rsp(1'b0, 20, n);
      chk("cont3_rsp_p_a", bus.rsp_p_a, 225);

      // Timeout: multiplier never answers
      m_hang = 1'b1;
      tick();
      bus.q_a = 4'd6; bus.r_a = 4'd7; bus.req_a = 1'b1;
      tick();
      chk("to_gnt_a", bus.gnt_a, 1);
      bus.req_a = 1'b0;
      wait_rsp(1'b0, 100, n);
      chk("to_latency", n, TIMEOUT + 1);
      chk("to_err_a", bus.rsp_err_a, 1);
      chk("to_rsp_p_a", bus.rsp_p_a, 0);
      chk("to_rsp_p_b_held", bus.rsp_p_b, 14);
      chk("to_rsp_err_b", bus.rsp_err_b, 0);

      // Late Done with a pending request: drain first, no grant meanwhile
      model_en = 1'b0; man_p = 8'd99; man_done = 1'b1; bus.req_a = 1'b1;
      g0 = n_gnt_a;
      tick(); tick();
      chk("drain_busy", bus.busy, 1);
      chk("drain_ack", bus.mul_ack, 1);
      tick(); tick(); tick();
      chk("drain_ack_held", bus.mul_ack, 1);
      chk("drain_no_gnt", n_gnt_a - g0, 0);
      man_done = 1'b0; model_en = 1'b1; m_hang = 1'b0;
      tick();
      chk("drain_exit_ack", bus.mul_ack, 0);
      chk("drain_exit_busy", bus.busy, 0);
      tick();
      chk("post_drain_gnt_a", bus.gnt_a, 1);
      chk("post_drain_mul_q", bus.mul_q, 6);
      bus.req_a = 1'b0;
      wait_rsp(1'b0, 20, n);
      chk("post_drain_latency", n, 7);
      chk("post_drain_rsp_p_a", bus.rsp_p_a, 42);
      chk("post_drain_err_a", bus.rsp_err_a, 0);

      // Reset asserted mid-WAIT
      tick();
      bus.q_a = 4'd3; bus.r_a = 4'd5; bus.req_a = 1'b1;
      tick();
      chk("mid_gnt_a", bus.gnt_a, 1);
      bus.req_a = 1'b0;
      tick(); tick();
      chk("mid_busy", bus.busy, 1);
      r0 = n_rsp_a;
      #2 rst_n = 1'b0;
      #1 chk("mid_async_outputs", 64'(outs), 0);
      tick(); tick();
      rst_n = 1'b1;
      bus.q_b = 4'd2; bus.r_b = 4'd7; bus.req_b = 1'b1;
      tick();
      chk("post_rst_gnt_b", bus.gnt_b, 1);
      chk("post_rst_gnt_a", bus.gnt_a, 0);
      bus.req_b = 1'b0;
      wait_rsp(1'b1, 20, n);
      chk("post_rst_latency", n, 7);
      chk("post_rst_rsp_p_b", bus.rsp_p_b, 14);
      chk("post_rst_no_rsp_a", n_rsp_a - r0, 0);

      // Exhaustive sweep on requester A, back-to-back
      tick();
      for (int q = 0; q < 16; q++) begin
         for (int r = 0; r < 16; r++) begin
            bus.q_a = 4'(q); bus.r_a = 4'(r); bus.req_a = 1'b1;
            n = 0;
            do begin
               tick();
               n++;
            end while (!bus.gnt_a && n < 10);
            chk("sweep_gnt_gap", n, (q == 0 && r == 0) ? 1 : 2);
            bus.req_a = 1'b0;
            wait_rsp(1'b0, 20, n);
            chk("sweep_product", bus.rsp_p_a, 64'(q * r));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
